// File: rtl/decode_operand_fetch.sv
// Decode/operand-fetch stage: splits the instruction, reads the register file,
// flags operands to forward from execute, and stalls fetch on LOAD or after HLT.
module decode_operand_fetch #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instrValid,
  output logic              stall,
  output logic [REG_AW-1:0] rdAddr1,
  output logic [REG_AW-1:0] rdAddr2,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2,
  input  logic              loadDone,
  output logic [OP_W-1:0]   opcode,
  output logic [REG_AW-1:0] destReg,
  output logic [DATA_W-1:0] srcVal1,
  output logic [DATA_W-1:0] srcVal2,
  output logic [MEM_AW-1:0] memAddr,
  output logic              used1,
  output logic              used2,
  output logic              halted
);

  localparam logic [3:0] OP_HLT   = 4'd1;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_STORE = 4'd15;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        op_p0;
  logic              is_alu_p0;
  logic              is_load_p0;
  logic              is_store_p0;
  logic              reads1_p0;
  logic              reads2_p0;
  logic              issue_p0;
  logic [REG_AW-1:0] addr1_p0;
  logic [REG_AW-1:0] addr2_p0;
  logic [REG_AW-1:0] dest_p0;
  logic [DATA_W-1:0] src1_p0;
  logic [DATA_W-1:0] src2_p0;
  logic [MEM_AW-1:0] mem_p0;
  logic              used1_p0;
  logic              used2_p0;

  logic [OP_W-1:0]   opcode_p1;
  logic [REG_AW-1:0] dest_p1;
  logic [DATA_W-1:0] src1_p1;
  logic [DATA_W-1:0] src2_p1;
  logic [MEM_AW-1:0] mem_p1;
  logic              used1_p1;
  logic              used2_p1;
  logic              fwd_vld_p1;
  logic [REG_AW-1:0] fwd_dest_p1;

  // ---- stage p0: control FSM (RUN / waiting on LOAD / halted) ----
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (issue_p0 && is_load_p0)       state_nxt = ST_LOAD;
        else if (issue_p0 && op_p0 == OP_HLT) state_nxt = ST_HALT;
      end
      ST_LOAD: if (loadDone) state_nxt = ST_RUN;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Stall depends on registered state only, so fetch never sees a path from instr.
  always_comb begin
    stall  = 1'b1;
    halted = 1'b0;
    case (state)
      ST_RUN:  stall = 1'b0;
      ST_LOAD: stall = 1'b1;
      ST_HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: stall = 1'b1;
    endcase
  end

  // ---- stage p0: field split and operand selection ----
  always_comb begin
    op_p0       = instr[15:12];
    is_alu_p0   = (op_p0 >= 4'd2) && (op_p0 <= 4'd10);
    is_load_p0  = (op_p0 == OP_LOAD);
    is_store_p0 = (op_p0 == OP_STORE);
    reads1_p0   = is_alu_p0 || is_store_p0;
    reads2_p0   = is_alu_p0 && (op_p0 != OP_NOT);
    issue_p0    = instrValid && !stall;

    // STORE reads its data register from the destination field.
    addr1_p0 = is_store_p0 ? REG_AW'(instr[11:8]) : REG_AW'(instr[7:4]);
    addr2_p0 = REG_AW'(instr[3:0]);
    dest_p0  = REG_AW'(instr[11:8]);
    src1_p0  = reads1_p0 ? rdData1 : '0;
    src2_p0  = reads2_p0 ? rdData2 : '0;
    mem_p0   = (is_load_p0 || is_store_p0) ? MEM_AW'(instr[7:0]) : '0;

    // Only the immediately preceding ALU result is still in flight in execute.
    used1_p0 = fwd_vld_p1 && reads1_p0 && (addr1_p0 == fwd_dest_p1);
    used2_p0 = fwd_vld_p1 && reads2_p0 && (addr2_p0 == fwd_dest_p1);
  end

  assign rdAddr1 = addr1_p0;
  assign rdAddr2 = addr2_p0;

  // ---- stage p1: issue register (bubble = all-zero NOP) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_p1  <= '0;
      dest_p1    <= '0;
      src1_p1    <= '0;
      src2_p1    <= '0;
      mem_p1     <= '0;
      used1_p1   <= 1'b0;
      used2_p1   <= 1'b0;
      fwd_vld_p1 <= 1'b0;
    end else if (issue_p0) begin
      opcode_p1  <= OP_W'(op_p0);
      dest_p1    <= dest_p0;
      src1_p1    <= src1_p0;
      src2_p1    <= src2_p0;
      mem_p1     <= mem_p0;
      used1_p1   <= used1_p0;
      used2_p1   <= used2_p0;
      fwd_vld_p1 <= is_alu_p0;
    end else begin
      opcode_p1  <= '0;
      dest_p1    <= '0;
      src1_p1    <= '0;
      src2_p1    <= '0;
      mem_p1     <= '0;
      used1_p1   <= 1'b0;
      used2_p1   <= 1'b0;
      fwd_vld_p1 <= 1'b0;
    end
  end

  // Forwarding tag is data; its validity is qualified by fwd_vld_p1.
  always_ff @(posedge clk) begin
    fwd_dest_p1 <= dest_p0;
  end

  assign opcode  = opcode_p1;
  assign destReg = dest_p1;
  assign srcVal1 = src1_p1;
  assign srcVal2 = src2_p1;
  assign memAddr = mem_p1;
  assign used1   = used1_p1;
  assign used2   = used2_p1;

endmodule
